// File: rtl/uart_send_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame width and the
// default clock/baud parameters common to uart_send and uart_recv.
package uart_send_pkg;

  localparam int unsigned UART_DATA_BITS        = 8;
  localparam int unsigned UART_DEFAULT_CLK_FREQ = 100_000_000;
  localparam int unsigned UART_DEFAULT_BAUD     = 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_send_fifo.sv
// Byte FIFO feeding the UART transmitter. Head is read combinationally;
// pointers wrap naturally because DEPTH is a power of two.
module uart_send_fifo
  import uart_send_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;

  // Storage, pointers and occupancy; reset discards all queued bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_send.sv
// UART 8N1 transmitter with a small input FIFO. dout is registered so the
// line never glitches; back-to-back frames leave no idle gap.
module uart_send
  import uart_send_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = UART_DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD       = UART_DEFAULT_BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      dout,
  output logic                      busy
);

  localparam int unsigned DIVIDER = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int unsigned BIT_W   = $clog2(UART_DATA_BITS);

  uart_state_t               state;
  logic [CNT_W-1:0]          baud_cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      alive;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      baud_last;

  uart_send_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Holds ready low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  assign baud_last = (baud_cnt == CNT_W'(DIVIDER - 1));
  assign ready     = alive && !fifo_full;
  assign fifo_push = valid && ready;
  assign fifo_pop  = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && baud_last));
  assign busy      = (state != IDLE) || !fifo_empty;

  // Frame sequencer: dout is loaded one cycle ahead with the next bit value
  // so each bit sits on the line for exactly DIVIDER cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dout     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          dout <= 1'b1;
          if (fifo_pop) begin
            shift    <= fifo_head;
            baud_cnt <= '0;
            state    <= START;
            dout     <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            dout     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              dout  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              dout    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shift <= fifo_head;
              state <= START;
              dout  <= 1'b0;
            end else begin
              state <= IDLE;
              dout  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          dout  <= 1'b1;
        end
      endcase
    end
  end

endmodule
